write_iq: RTL and testbench
===========================

WRITE_IQ -- requirements
Module: write_iq

Interface
REQ-001 Parameter SAT_CNT_WIDTH, default 16, width of saturation event counter.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 inI_rd_en  output  1  read strobe, I-sample input FIFO.
REQ-005 inI_empty  input  1  I FIFO empty flag.
REQ-006 inI_dout  input  32  signed quantized I sample (fixed point, GLOBALS::BITS fractional bits).
REQ-007 inQ_rd_en  output  1  read strobe, Q-sample input FIFO.
REQ-008 inQ_empty  input  1  Q FIFO empty flag.
REQ-009 inQ_dout  input  32  signed quantized Q sample, same format as I.
REQ-010 out_wr_en  output  1  write strobe, packed IQ output FIFO.
REQ-011 out_full  input  1  output FIFO full flag.
REQ-012 out_din  output  32  packed byte stream word: {I[7:0], I[15:8], Q[7:0], Q[15:8]}.
REQ-013 sat_count  output  SAT_CNT_WIDTH  number of 16-bit saturation events since reset.

Function
REQ-014 Block SHALL be the inverse of the IQ byte-stream reader: dequantize, saturate, byte-pack I/Q pairs into one 32-bit word.
REQ-015 FSM SHALL have two states: S_READ, S_WRITE; unreachable encodings SHALL return to S_READ with packed word cleared.
REQ-016 S_READ: when inI_empty=0 AND inQ_empty=0, assert inI_rd_en and inQ_rd_en together for exactly one cycle, register packed word, go to S_WRITE.
REQ-017 S_READ: if either FIFO empty, assert neither rd_en; never read one FIFO without the other.
REQ-018 S_WRITE: when out_full=0, assert out_wr_en one cycle with out_din = registered word, go to S_READ; when out_full=1, hold state and word, out_wr_en=0.
REQ-019 out_din SHALL be 0 in every cycle out_wr_en=0; rd_en/wr_en never asserted in same cycle.
REQ-020 Dequantize: arithmetic shift right by GLOBALS::BITS (truncation toward minus infinity), 32-bit signed.
REQ-021 Saturate dequantized value to [-32768, 32767]; in-range values pass unchanged as 16-bit two's complement.
REQ-022 Each clamped sample (I and Q counted independently) SHALL add 1 to sat_count in the S_READ accept cycle (up to +2 per word).
REQ-023 sat_count SHALL stick at all-ones, never wrap.
REQ-024 Throughput: one output word per 2 cycles max; latency accept-to-write = 1 cycle when out_full=0.

Reset
REQ-025 Reset SHALL force state S_READ, packed word 0, sat_count 0; all strobes 0 and out_din 0 while reset high.
REQ-026 Reset asserted in S_WRITE SHALL drop the pending word without writing; consumed input samples are not re-read.

Structure
REQ-027 GLOBALS package SHALL own BITS and a DEQUANTIZE function (inverse of QUANTIZE_I); block SHALL not redefine them.
REQ-028 State typedef local to module; saturation/pack logic in one sub-module iq_sat_pack (combinational, two 32-bit in, 32-bit word + two sat flags out).

Verification (BITS=10)
REQ-029 I=0x0004B000, Q=0xFFFFF800, out_full=0 -> one write, out_din=0x2C01FEFF, sat_count unchanged.
REQ-030 I=0x7FFFFFFF, Q=0x80000000 -> out_din=0xFF7F0080, sat_count +2.
REQ-031 I=0xFFFFFFFF, Q=0x000003FF -> out_din=0xFFFF0000 (truncation), no saturation.
REQ-032 inI_empty=0, inQ_empty=1 for 10 cycles -> no rd_en asserted; read both cycle after inQ_empty falls.
REQ-033 out_full=1 for 5 cycles in S_WRITE -> out_wr_en low, no further reads, word written unchanged first cycle out_full=0.
REQ-034 Reset pulse in S_WRITE -> no write, sat_count=0, next pair packed correctly; force sat_count to all-ones-1 then two clamps -> stays all-ones.

Source files
------------

// File: rtl/write_iq_pkg.sv
// Shared fixed-point globals: fractional bit count and the dequantizer that
// undoes the sample quantizer.
package GLOBALS;
   localparam int BITS = 10;

   // Arithmetic shift rounds toward minus infinity.
   function automatic logic signed [31:0] DEQUANTIZE(input logic signed [31:0] v);
      return v >>> BITS;
   endfunction
endpackage

// File: rtl/iq_sat_pack.sv
// Dequantizes one I/Q pair, clamps each to 16 bits and byte-packs the result
// little-endian per sample: {I[7:0], I[15:8], Q[7:0], Q[15:8]}.
module iq_sat_pack
   import GLOBALS::*;
(
   input  logic [31:0] i_raw,
   input  logic [31:0] q_raw,
   output logic [31:0] word,
   output logic        i_sat,
   output logic        q_sat
);

   function automatic logic [16:0] sat16(input logic signed [31:0] v);
      if (v > 32'sd32767)
         return {1'b1, 16'h7FFF};
      else if (v < -32'sd32768)
         return {1'b1, 16'h8000};
      return {1'b0, v[15:0]};
   endfunction

   logic [16:0] i_res, q_res;

   always_comb begin
      i_res = sat16(DEQUANTIZE($signed(i_raw)));
      q_res = sat16(DEQUANTIZE($signed(q_raw)));
      i_sat = i_res[16];
      q_sat = q_res[16];
      word  = {i_res[7:0], i_res[15:8], q_res[7:0], q_res[15:8]};
   end

endmodule

// File: rtl/write_iq.sv
// IQ byte-stream writer: pops an I/Q sample pair together, packs it into one
// 32-bit word and pushes that word to the output FIFO, counting clamps.
module write_iq
   import GLOBALS::*;
#(
   parameter int SAT_CNT_WIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic                     inI_rd_en,
   input  logic                     inI_empty,
   input  logic [31:0]              inI_dout,
   output logic                     inQ_rd_en,
   input  logic                     inQ_empty,
   input  logic [31:0]              inQ_dout,
   output logic                     out_wr_en,
   input  logic                     out_full,
   output logic [31:0]              out_din,
   output logic [SAT_CNT_WIDTH-1:0] sat_count
);

   typedef enum logic [1:0] {
      S_READ  = 2'd0,
      S_WRITE = 2'd1
   } state_t;

   state_t                   state_q, state_d;
   logic [31:0]              word_q, word_d;
   logic [SAT_CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;

   logic [31:0]              pack_word;
   logic                     i_sat, q_sat;
   logic [SAT_CNT_WIDTH:0]   sat_sum;
   logic                     rd_en, wr_en;

   iq_sat_pack u_pack (
      .i_raw (inI_dout),
      .q_raw (inQ_dout),
      .word  (pack_word),
      .i_sat (i_sat),
      .q_sat (q_sat)
   );

   // One extra bit catches the carry so the counter sticks at all-ones.
   always_comb begin
      sat_sum = {1'b0, sat_cnt_q}
              + {{SAT_CNT_WIDTH{1'b0}}, i_sat}
              + {{SAT_CNT_WIDTH{1'b0}}, q_sat};
   end

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      sat_cnt_d = sat_cnt_q;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      case (state_q)
         S_READ: begin
            if (!inI_empty && !inQ_empty) begin
               rd_en     = 1'b1;
               word_d    = pack_word;
               sat_cnt_d = sat_sum[SAT_CNT_WIDTH] ? '1 : sat_sum[SAT_CNT_WIDTH-1:0];
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!out_full) begin
               wr_en   = 1'b1;
               state_d = S_READ;
            end
         end
         default: begin
            state_d = S_READ;
            word_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_READ;
         word_q    <= '0;
         sat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         sat_cnt_q <= sat_cnt_d;
      end
   end

   // Strobes are masked while reset is high so nothing is consumed or written.
   always_comb begin
      inI_rd_en = rd_en & ~reset;
      inQ_rd_en = rd_en & ~reset;
      out_wr_en = wr_en & ~reset;
      out_din   = out_wr_en ? word_q : '0;
      sat_count = sat_cnt_q;
   end

endmodule

// File: tb/tb_write_iq.sv
// Randomized scoreboard bench for write_iq with a floor-division reference model.
module tb_write_iq;
   localparam int SW   = 5;
   localparam int MAXC = (1 << SW) - 1;

   logic          clock, reset;
   logic          inI_rd_en, inI_empty, inQ_rd_en, inQ_empty;
   logic [31:0]   inI_dout, inQ_dout;
   logic          out_wr_en, out_full;
   logic [31:0]   out_din;
   logic [SW-1:0] sat_count;

   write_iq #(.SAT_CNT_WIDTH(SW)) dut (
      .clock(clock), .reset(reset),
      .inI_rd_en(inI_rd_en), .inI_empty(inI_empty), .inI_dout(inI_dout),
      .inQ_rd_en(inQ_rd_en), .inQ_empty(inQ_empty), .inQ_dout(inQ_dout),
      .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
      .sat_count(sat_count)
   );

   typedef struct { logic [31:0] word; int sat; } exp_t;
   exp_t        exp_q[$];
   logic [31:0] fI[$], fQ[$];
   bit          hideI, hideQ, rd_seen;
   int          model_sat;
   int          errors = 0, checks = 0;

   logic [31:0] bnd[7] = '{32'h01FFFFFF, 32'h02000000, 32'hFE000000, 32'hFDFFFFFF,
                           32'h000003FF, 32'hFFFFFC00, 32'hFFFFFBFF};

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   // Reference: floor(x / 2^10), then clamp to the signed 16-bit range.
   function automatic logic [15:0] ref_sample(input logic [31:0] raw, output bit clamped);
      longint v, r, f;
      v = $signed(raw);
      r = ((v % 1024) + 1024) % 1024;
      f = (v - r) / 1024;
      clamped = 0;
      if (f > 32767) begin f = 32767; clamped = 1; end
      else if (f < -32768) begin f = -32768; clamped = 1; end
      return f[15:0];
   endfunction

   task automatic push_pair(input logic [31:0] i, input logic [31:0] q);
      bit ci, cq;
      logic [15:0] iw, qw;
      exp_t e;
      iw = ref_sample(i, ci);
      qw = ref_sample(q, cq);
      model_sat = model_sat + int'(ci) + int'(cq);
      if (model_sat > MAXC) model_sat = MAXC;
      e.word = {iw[7:0], iw[15:8], qw[7:0], qw[15:8]};
      e.sat  = model_sat;
      exp_q.push_back(e);
      fI.push_back(i);
      fQ.push_back(q);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clock);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
   endtask

   task automatic wait_rd(input int budget);
      int n = 0;
      @(negedge clock);
      while (!inI_rd_en && n < budget) begin
         @(negedge clock);
         n++;
      end
      chk("read_seen", {31'b0, inI_rd_en}, 32'd1);
   endtask

   function automatic logic [31:0] rand_sample();
      int s;
      case ($urandom_range(0, 4))
         0: return $urandom;
         1: begin
            s = int'($urandom_range(0, 65535)) - 32768;
            return 32'(s * 1024 + int'($urandom_range(0, 1023)));
         end
         default: return bnd[$urandom_range(0, 6)];
      endcase
   endfunction

   // Input FIFO model: pops on a sampled read, presents the head afterwards.
   initial begin
      inI_empty = 1; inQ_empty = 1; inI_dout = 0; inQ_dout = 0;
      forever begin
         @(posedge clock);
         #1;
         if (rd_seen && fI.size() != 0 && fQ.size() != 0) begin
            void'(fI.pop_front());
            void'(fQ.pop_front());
         end
         inI_empty = hideI || fI.size() == 0;
         inQ_empty = hideQ || fQ.size() == 0;
         inI_dout  = fI.size() != 0 ? fI[0] : 32'h0;
         inQ_dout  = fQ.size() != 0 ? fQ[0] : 32'h0;
      end
   end

   // Monitor: per-cycle protocol rules plus scoreboard pop on every write.
   initial begin
      exp_t e;
      bit ok;
      forever begin
         @(negedge clock);
         rd_seen = inI_rd_en;
         checks++;
         if (reset) begin
            if (inI_rd_en || inQ_rd_en || out_wr_en || out_din != 0) begin
               errors++;
               $display("FAIL reset_outputs: got rd=%b/%b wr=%b din=%h expected all 0",
                        inI_rd_en, inQ_rd_en, out_wr_en, out_din);
            end
         end else begin
            ok = (inI_rd_en == inQ_rd_en)
               && !(inI_rd_en && (inI_empty || inQ_empty))
               && !(inI_rd_en && out_wr_en)
               && (out_wr_en || out_din == 0)
               && !(out_wr_en && out_full);
            if (!ok) begin
               errors++;
               $display("FAIL protocol: got rdI=%b rdQ=%b eI=%b eQ=%b wr=%b full=%b din=%h expected legal handshake",
                        inI_rd_en, inQ_rd_en, inI_empty, inQ_empty, out_wr_en, out_full, out_din);
            end
            if (out_wr_en) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_write: got din=%h expected no write", out_din);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_din", out_din, e.word);
                  chk("sat_count", 32'(sat_count), 32'(e.sat));
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      reset = 1; out_full = 0; hideI = 0; hideQ = 0; model_sat = 0; rd_seen = 0;
      repeat (3) @(posedge clock);
      #2;
      chk("reset_sat", 32'(sat_count), 32'd0);
      reset = 0;

      // Known vectors: normal, double clamp, truncation toward minus infinity.
      push_pair(32'h0004B000, 32'hFFFFF800);
      wait_drain(50);
      push_pair(32'h7FFFFFFF, 32'h80000000);
      wait_drain(50);
      push_pair(32'hFFFFFFFF, 32'h000003FF);
      wait_drain(50);

      // Q held empty: nothing may be read until it fills.
      @(posedge clock); #2;
      hideQ = 1;
      push_pair(32'h00012345, 32'hFFF00000);
      repeat (10) begin
         @(negedge clock);
         chk("hold_no_rd", {31'b0, inI_rd_en | inQ_rd_en}, 32'd0);
      end
      @(posedge clock); #2;
      hideQ = 0;
      @(posedge clock);
      @(negedge clock);
      chk("rd_after_release", {31'b0, inI_rd_en & inQ_rd_en}, 32'd1);
      wait_drain(50);

      // Output backpressure holds the word and blocks further reads.
      @(posedge clock); #2;
      out_full = 1;
      push_pair(32'h00400000, 32'hFF800000);
      push_pair(32'h00000C00, 32'h7FFFFFFF);
      wait_rd(20);
      repeat (5) begin
         @(negedge clock);
         chk("full_no_wr", {31'b0, out_wr_en}, 32'd0);
         chk("full_no_rd", {31'b0, inI_rd_en}, 32'd0);
      end
      @(posedge clock); #2;
      out_full = 0;
      wait_drain(50);

      // Reset while a word is pending drops it.
      @(posedge clock); #2;
      out_full = 1;
      push_pair(32'h7FFFFFFF, 32'h00000400);
      wait_rd(20);
      @(posedge clock); #2;
      reset = 1;
      void'(exp_q.pop_front());
      model_sat = 0;
      @(posedge clock); #2;
      reset = 0;
      out_full = 0;
      chk("sat_after_reset", 32'(sat_count), 32'd0);
      repeat (4) @(posedge clock);
      push_pair(32'h00001400, 32'hFFFFEC00);
      wait_drain(50);

      // Walk the counter to all-ones minus one, then clamp twice more.
      while (model_sat < MAXC - 1) begin
         if (MAXC - 1 - model_sat >= 2) push_pair(32'h7FFFFFFF, 32'h80000000);
         else                           push_pair(32'h7FFFFFFF, 32'h00000000);
      end
      wait_drain(500);
      chk("sat_at_max_minus_1", 32'(sat_count), 32'(MAXC - 1));
      push_pair(32'h80000000, 32'h7FFFFFFF);
      push_pair(32'h80000000, 32'h80000000);
      wait_drain(50);
      chk("sat_stuck", 32'(sat_count), 32'(MAXC));

      // Random traffic with random backpressure and empty gaps.
      for (int k = 0; k < 80; k++) begin
         @(posedge clock); #2;
         out_full = ($urandom_range(0, 3) == 0);
         hideI    = ($urandom_range(0, 5) == 0);
         hideQ    = ($urandom_range(0, 5) == 0);
         push_pair(rand_sample(), rand_sample());
         repeat ($urandom_range(0, 3)) @(posedge clock);
      end
      @(posedge clock); #2;
      out_full = 0; hideI = 0; hideQ = 0;
      wait_drain(3000);
      repeat (3) @(posedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
